regfile_2w2r: RTL and testbench
===============================

Name: regfile_2w2r

Overview:
Parametrised multi-port register file, successor to the single-write regfile used by the CPU datapath.
- Two write ports with a fixed collision priority; two combinational read ports plus a debug test port.
- Optional hardwired-zero entry 0.
- Sequential clear engine wipes the whole array on request, one entry per cycle, with a busy/done handshake.
- Sits between the decode stage (reads) and the writeback stage (writes); the test port feeds the board display.

Parameters:
DATA_W, 32, width of each register in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries (localparam, not overridable)
ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes; 0 = entry 0 is an ordinary register

Ports:
clk  in  1  single clock, all state updates on rising edge
resetn  in  1  asynchronous active-low reset
wen0  in  1  write enable, port 0
waddr0  in  ADDR_W  write address, port 0
wdata0  in  DATA_W  write data, port 0
wen1  in  1  write enable, port 1 (higher priority)
waddr1  in  ADDR_W  write address, port 1
wdata1  in  DATA_W  write data, port 1
raddr1  in  ADDR_W  read address, port 1
rdata1  out  DATA_W  read data, port 1
raddr2  in  ADDR_W  read address, port 2
rdata2  out  DATA_W  read data, port 2
test_addr  in  ADDR_W  debug read address
test_data  out  DATA_W  debug read data, never bypassed
clr_req  in  1  single-cycle request to clear the whole array
clr_busy  out  1  high while the clear sweep runs
clr_done  out  1  one-cycle pulse after the last entry is cleared

Behaviour:
- Reset (resetn=0, asynchronous):
  - All entries are set to 0 and the FSM goes to IDLE with clr_ptr=0.
  - clr_busy=0, clr_done=0; rdata1, rdata2 and test_data therefore read 0.
- Reads are combinational from the array with zero latency; results change in the same cycle as the address.
- Writes: if wenX=1 at a rising edge, entry waddrX takes wdataX, visible to reads after that edge.
- Write collision: if wen0=wen1=1 and waddr0==waddr1, port 1's data is stored and port 0's is dropped.
- ZERO_REG=1:
  - Writes to address 0 are discarded.
  - rdata1, rdata2 and test_data for address 0 are always 0, and bypass never applies to address 0.
- Clear FSM, states IDLE and CLEAR:
  - IDLE: clr_req=1 at an edge -> CLEAR with clr_ptr=0; clr_busy goes high the following cycle.
  - CLEAR: each edge writes 0 to entry clr_ptr, then clr_ptr increments.
  - When clr_ptr == DEPTH-1 is cleared -> IDLE, clr_busy falls and clr_done pulses for one cycle.
  - Total busy time is exactly DEPTH cycles.
- During CLEAR:
  - wen0 and wen1 are ignored, so user writes are lost; the writer must stall on clr_busy.
  - clr_req is ignored; no restart and no queueing.
  - Reads stay live: cleared entries read 0 and uncleared entries keep their old value.
- If clr_req and a write arrive in the same IDLE cycle, the write completes at that edge and the sweep then clears it.
- resetn deasserting mid-sweep aborts it: the array is zeroed by reset and no clr_done pulse is produced.
- clr_ptr width is ADDR_W; its wrap on the final increment is don't-care because the FSM leaves CLEAR.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-through forwarding on rdata1 and rdata2.
  - If a read address matches an active write address in the current cycle, the read returns that write's data.
  - Port 1 beats port 0 on a double match.
  - Inactive during CLEAR (writes are ignored there) and never applied to test_data.
- Undefined: reads return stored contents only; new data appears the cycle after the write edge.

Test Plan:
- Reset, then read 0..31 on all three read ports -> all return 32'h0; clr_busy=0.
- wen0=1 waddr0=3 wdata0=32'h7d for one edge; then raddr1=3, raddr2=3, test_addr=3 -> all read 32'h7d.
- wen0=wen1=1, waddr0=waddr1=5, wdata0=32'h11, wdata1=32'h22 -> entry 5 reads 32'h22. Then write 32'hff to addr 0 -> addr 0 reads 0 with ZERO_REG=1, and 32'hff with ZERO_REG=0.
- Fill entries 1..31 with their own index, pulse clr_req:
  - clr_busy high for exactly 32 cycles; clr_done pulses once.
  - Mid-sweep, entries above clr_ptr still hold their index.
  - A wen0 to addr 31 during the sweep has no effect; afterwards all entries read 0.
- Start a sweep, assert resetn=0 at cycle 10 -> clr_busy drops immediately, all entries read 0, no clr_done pulse.
- REGFILE_BYPASS_EN defined: wen1=1 waddr1=7 wdata1=32'hcafe with raddr1=7 in the same cycle -> rdata1=32'hcafe before the edge, while test_addr=7 still shows the old value. Undefined: rdata1 shows the old value until after the edge.

Source files
------------

// File: rtl/regfile_2w2r.sv
// Two-write / two-read register file with a debug read port and a one-entry-per-cycle clear engine.
// Optional macro REGFILE_BYPASS_EN adds write-through forwarding on rdata1/rdata2.
module regfile_2w2r #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wen0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              wen1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic [ADDR_W-1:0] test_addr,
  output logic [DATA_W-1:0] test_data,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              clr_busy_q, clr_busy_d;
  logic              clr_done_q, clr_done_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    clr_busy_d = clr_busy_q;
    clr_done_d = 1'b0;
    mem_d      = mem_q;
    case (state_q)
      StIdle: begin
        // Port 1 is applied last so it wins an address collision.
        if (wen0) mem_d[waddr0] = wdata0;
        if (wen1) mem_d[waddr1] = wdata1;
        if (clr_req) begin
          state_d    = StClear;
          clr_ptr_d  = '0;
          clr_busy_d = 1'b1;
        end
      end
      StClear: begin
        mem_d[clr_ptr_q] = '0;
        clr_ptr_d        = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == LastAddr) begin
          state_d    = StIdle;
          clr_busy_d = 1'b0;
          clr_done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (ZERO_REG != 0) mem_d[0] = '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      clr_ptr_q  <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      clr_busy_q <= clr_busy_d;
      clr_done_q <= clr_done_d;
      mem_q      <= mem_d;
    end
  end

  assign clr_busy = clr_busy_q;
  assign clr_done = clr_done_q;

  always_comb begin
    rdata1    = mem_q[raddr1];
    rdata2    = mem_q[raddr2];
    test_data = mem_q[test_addr];
`ifdef REGFILE_BYPASS_EN
    // Writes are dropped during a sweep, so there is nothing to forward then.
    if (state_q == StIdle) begin
      if (wen1 && (waddr1 == raddr1))      rdata1 = wdata1;
      else if (wen0 && (waddr0 == raddr1)) rdata1 = wdata0;
      if (wen1 && (waddr1 == raddr2))      rdata2 = wdata1;
      else if (wen0 && (waddr0 == raddr2)) rdata2 = wdata0;
    end
`endif
    if (ZERO_REG != 0) begin
      if (raddr1 == '0)    rdata1    = '0;
      if (raddr2 == '0)    rdata2    = '0;
      if (test_addr == '0) test_data = '0;
    end
  end

endmodule

// File: tb/tb_regfile_2w2r.sv
// Directed bench for regfile_2w2r: two instances (ZERO_REG=1 and 0) checked every cycle
// against an array model, plus hand-computed literal expectations.
module tb_regfile_2w2r;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wen0, wen1, clr_req;
  logic [4:0]  waddr0, waddr1, raddr1, raddr2, test_addr;
  logic [31:0] wdata0, wdata1;
  logic [31:0] rdata1, rdata2, test_data;
  logic [31:0] rdata1_nz, rdata2_nz, test_data_nz;
  logic        clr_busy, clr_done, clr_busy_nz, clr_done_nz;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  regfile_2w2r u_dut (
    .clk(clk), .resetn(resetn),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr1(raddr1), .rdata1(rdata1), .raddr2(raddr2), .rdata2(rdata2),
    .test_addr(test_addr), .test_data(test_data),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  regfile_2w2r #(.ZERO_REG(0)) u_dut_nz (
    .clk(clk), .resetn(resetn),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr1(raddr1), .rdata1(rdata1_nz), .raddr2(raddr2), .rdata2(rdata2_nz),
    .test_addr(test_addr), .test_data(test_data_nz),
    .clr_req(clr_req), .clr_busy(clr_busy_nz), .clr_done(clr_done_nz)
  );

  // Model: array contents per instance, plus sweep progress counter.
  logic [31:0] m_z  [32];
  logic [31:0] m_nz [32];
  bit          sweeping, done_exp;
  int          sweep_idx;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) begin
        m_z[i]  <= '0;
        m_nz[i] <= '0;
      end
      sweeping  <= 1'b0;
      done_exp  <= 1'b0;
      sweep_idx <= 0;
    end else if (sweeping) begin
      m_z[sweep_idx]  <= '0;
      m_nz[sweep_idx] <= '0;
      sweep_idx       <= sweep_idx + 1;
      done_exp        <= (sweep_idx == 31);
      if (sweep_idx == 31) sweeping <= 1'b0;
    end else begin
      done_exp <= 1'b0;
      if (wen0) begin
        m_nz[waddr0] <= wdata0;
        if (waddr0 != 0) m_z[waddr0] <= wdata0;
      end
      if (wen1) begin
        m_nz[waddr1] <= wdata1;
        if (waddr1 != 0) m_z[waddr1] <= wdata1;
      end
      if (clr_req) begin
        sweeping  <= 1'b1;
        sweep_idx <= 0;
      end
    end
  end

  function automatic logic [31:0] exp_rd(input bit zr, input logic [4:0] a);
    if (zr && a == 0) return 32'h0;
    return zr ? m_z[a] : m_nz[a];
  endfunction

  function automatic logic [31:0] exp_fwd(input bit zr, input logic [4:0] a);
`ifdef REGFILE_BYPASS_EN
    if (!(zr && a == 0) && !sweeping) begin
      if (wen1 && waddr1 == a) return wdata1;
      if (wen0 && waddr0 == a) return wdata0;
    end
`endif
    return exp_rd(zr, a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_rdata1",      rdata1,       exp_fwd(1'b1, raddr1));
      check("cmp_rdata2",      rdata2,       exp_fwd(1'b1, raddr2));
      check("cmp_test_data",   test_data,    exp_rd(1'b1, test_addr));
      check("cmp_rdata1_nz",   rdata1_nz,    exp_fwd(1'b0, raddr1));
      check("cmp_rdata2_nz",   rdata2_nz,    exp_fwd(1'b0, raddr2));
      check("cmp_test_nz",     test_data_nz, exp_rd(1'b0, test_addr));
      check("cmp_clr_busy",    {31'b0, clr_busy},    {31'b0, sweeping});
      check("cmp_clr_done",    {31'b0, clr_done},    {31'b0, done_exp});
      check("cmp_clr_busy_nz", {31'b0, clr_busy_nz}, {31'b0, sweeping});
      check("cmp_clr_done_nz", {31'b0, clr_done_nz}, {31'b0, done_exp});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int busy_cnt, done_cnt;

  initial begin
    resetn = 1'b0; wen0 = 1'b0; wen1 = 1'b0; clr_req = 1'b0;
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
    raddr1 = '0; raddr2 = '0; test_addr = '0;
    chk_en = 1'b1;
    step(); step();
    resetn = 1'b1;
    check("reset_busy", {31'b0, clr_busy}, 32'h0);

    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a); raddr2 = 5'(31 - a); test_addr = 5'(a);
      #1 check("reset_rd1", rdata1, 32'h0);
      check("reset_test", test_data, 32'h0);
      step();
    end

    wen0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h7d;
    step();
    wen0 = 1'b0; raddr1 = 5'd3; raddr2 = 5'd3; test_addr = 5'd3;
    #1 check("wr3_rd1", rdata1, 32'h7d);
    check("wr3_rd2", rdata2, 32'h7d);
    check("wr3_test", test_data, 32'h7d);
    step();

    wen0 = 1'b1; wen1 = 1'b1; waddr0 = 5'd5; waddr1 = 5'd5;
    wdata0 = 32'h11; wdata1 = 32'h22;
    step();
    wen0 = 1'b0; wen1 = 1'b0; raddr1 = 5'd5;
    #1 check("collide_z", rdata1, 32'h22);
    check("collide_nz", rdata1_nz, 32'h22);
    wen0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hff;
    step();
    wen0 = 1'b0; raddr1 = 5'd0; test_addr = 5'd0;
    #1 check("zero_reg_rd", rdata1, 32'h0);
    check("zero_reg_test", test_data, 32'h0);
    check("plain_reg0_rd", rdata1_nz, 32'hff);
    step();

    // Fill 1..31 with own index, then sweep.
    for (int i = 1; i < 32; i++) begin
      wen0 = 1'b1; waddr0 = 5'(i); wdata0 = 32'(i);
      step();
    end
    wen0 = 1'b0;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      busy_cnt += int'(clr_busy);
      done_cnt += int'(clr_done);
      if (n == 10) begin
        test_addr = 5'd20; raddr1 = 5'd5; raddr2 = 5'd31;
        #1 check("mid_uncleared", test_data, 32'd20);
        check("mid_cleared", rdata1, 32'h0);
        check("mid_last", rdata2, 32'd31);
      end
      if (n == 12) begin wen0 = 1'b1; waddr0 = 5'd31; wdata0 = 32'hdead; end
      if (n == 13) wen0 = 1'b0;
      if (n == 15) clr_req = 1'b1;
      if (n == 16) clr_req = 1'b0;
      step();
    end
    check("busy_cycles", 32'(busy_cnt), 32'd32);
    check("done_pulses", 32'(done_cnt), 32'd1);
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a); test_addr = 5'(a);
      #1 check("post_clr_nz", rdata1_nz, 32'h0);
      step();
    end
    raddr2 = 5'd31;
    #1 check("post_clr_31", rdata2, 32'h0);

    // Reset in the middle of a sweep.
    for (int i = 1; i < 9; i++) begin
      wen1 = 1'b1; waddr1 = 5'(i); wdata1 = 32'ha0 + 32'(i);
      step();
    end
    wen1 = 1'b0;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int n = 0; n < 10; n++) step();
    resetn = 1'b0; test_addr = 5'd8; raddr1 = 5'd7;
    #1 check("abort_busy", {31'b0, clr_busy}, 32'h0);
    check("abort_test8", test_data, 32'h0);
    check("abort_rd7_nz", rdata1_nz, 32'h0);
    step(); step();
    resetn = 1'b1;
    done_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      raddr1 = 5'(n % 32); raddr2 = 5'((n + 7) % 32);
      done_cnt += int'(clr_done);
      step();
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);

    // Forwarding behaviour.
    wen0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h1234;
    step();
    wen0 = 1'b0;
    wen1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'hcafe;
    raddr1 = 5'd7; raddr2 = 5'd7; test_addr = 5'd7;
`ifdef REGFILE_BYPASS_EN
    #1 check("bypass_rd1", rdata1, 32'hcafe);
`else
    #1 check("nobypass_rd1", rdata1, 32'h1234);
`endif
    check("bypass_test_old", test_data, 32'h1234);
    step();
    wen1 = 1'b0;
    #1 check("after_edge_rd1", rdata1, 32'hcafe);
    check("after_edge_test", test_data, 32'hcafe);
    step();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
